// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift sequencer and the 8-bit shift register.
package shift_seq_ctrl_pkg;

   localparam int SR_WIDTH = 8;
   localparam int SR_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   localparam logic [1:0] FILL_ZERO  = 2'b00;
   localparam logic [1:0] FILL_ONE   = 2'b01;
   localparam logic [1:0] FILL_ROT   = 2'b10;
   localparam logic [1:0] FILL_ARITH = 2'b11;

   // Operation configuration captured when a request is accepted.
   typedef struct packed {
      logic [SR_WIDTH-1:0] load_val;
      logic                dir;
      logic [1:0]          fill;
   } cfg_t;

   // Rotation wraps every 8 positions; any other fill saturates once the
   // register has been fully flushed.
   function automatic logic [SR_CNT_W-1:0] eff_count(input logic [SR_CNT_W-1:0] amount,
                                                     input logic [1:0]          fill);
      logic [SR_CNT_W-1:0] n;
      if (fill == FILL_ROT)
         n = {1'b0, amount[2:0]};
      else if (amount > SR_CNT_W'(SR_WIDTH))
         n = SR_CNT_W'(SR_WIDTH);
      else
         n = amount;
      return n;
   endfunction

endpackage

// File: rtl/shift_reg_lr.sv
// 8-bit bidirectional shift register with parallel load.
module shift_reg_lr
   import shift_seq_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          mode,
   input  logic [SR_WIDTH-1:0] data_in,
   input  logic                shift_in_left,
   input  logic                shift_in_right,
   output logic [SR_WIDTH-1:0] data_out
);

   // Hold, shift toward LSB, shift toward MSB, or parallel load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_out <= '0;
      end else begin
         unique case (mode)
            MODE_RIGHT: data_out <= {shift_in_left, data_out[SR_WIDTH-1:1]};
            MODE_LEFT:  data_out <= {data_out[SR_WIDTH-2:0], shift_in_right};
            MODE_LOAD:  data_out <= data_in;
            default:    data_out <= data_out;
         endcase
      end
   end

endmodule

// File: rtl/shift_seq_ctrl_fill_sel.sv
// Fill-bit selection for the shift register's serial inputs.
module shift_fill_sel
   import shift_seq_ctrl_pkg::*;
(
   input  logic       active,
   input  logic       dir,
   input  logic [1:0] fill,
   input  logic       q_msb,
   input  logic       q_lsb,
   output logic       shift_in_left,
   output logic       shift_in_right
);

   // Only the pin feeding the active direction is driven; the other stays 0.
   always_comb begin
      shift_in_left  = 1'b0;
      shift_in_right = 1'b0;
      if (active) begin
         if (dir) begin
            unique case (fill)
               FILL_ONE: shift_in_right = 1'b1;
               FILL_ROT: shift_in_right = q_msb;
               default:  shift_in_right = 1'b0;
            endcase
         end else begin
            unique case (fill)
               FILL_ONE:   shift_in_left = 1'b1;
               FILL_ROT:   shift_in_left = q_lsb;
               FILL_ARITH: shift_in_left = q_msb;
               default:    shift_in_left = 1'b0;
            endcase
         end
      end
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequences load / N shifts / hold on shift_reg_lr for one whole operation.
module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = SR_WIDTH,
   parameter int CNT_W = SR_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   input  logic [CNT_W-1:0] amount,
   input  logic [1:0]       fill,
   input  logic [WIDTH-1:0] reg_q,
   output logic [1:0]       mode,
   output logic [WIDTH-1:0] data_in,
   output logic             shift_in_left,
   output logic             shift_in_right,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   state_t           state, state_nx;
   cfg_t             cfg;
   logic [CNT_W-1:0] cnt;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   // Config capture, remaining-shift counter, result and done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg    <= '0;
         cnt    <= '0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= (state == ST_DONE);
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  cfg.load_val <= load_val;
                  cfg.dir      <= dir;
                  cfg.fill     <= fill;
                  cnt          <= eff_count(amount, fill);
               end
            end
            ST_SHIFT: cnt <= cnt - 1'b1;
            ST_DONE:  result <= reg_q;
            default: ;
         endcase
      end
   end

   // Next state and register control decode.
   always_comb begin
      state_nx = state;
      mode     = MODE_HOLD;
      data_in  = '0;
      unique case (state)
         ST_IDLE: if (start) state_nx = ST_LOAD;
         ST_LOAD: begin
            mode     = MODE_LOAD;
            data_in  = cfg.load_val;
            state_nx = (cnt == '0) ? ST_DONE : ST_SHIFT;
         end
         ST_SHIFT: begin
            mode = cfg.dir ? MODE_LEFT : MODE_RIGHT;
            // cnt holds the shifts still to do including this one.
            if (cnt <= CNT_W'(1)) state_nx = ST_DONE;
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

   shift_fill_sel u_fill (
      .active         (state == ST_SHIFT),
      .dir            (cfg.dir),
      .fill           (cfg.fill),
      .q_msb          (reg_q[WIDTH-1]),
      .q_lsb          (reg_q[0]),
      .shift_in_left  (shift_in_left),
      .shift_in_right (shift_in_right)
   );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl driving a real shift_reg_lr.
module tb_shift_seq_ctrl;
   import shift_seq_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] load_val;
   logic       dir;
   logic [3:0] amount;
   logic [1:0] fill;
   logic [7:0] reg_q;
   logic [1:0] mode;
   logic [7:0] data_in;
   logic       shift_in_left, shift_in_right;
   logic       busy, done;
   logic [7:0] result;

   int checks = 0;
   int errors = 0;
   logic [1:0] mode_log[$];

   always #5 clk = ~clk;

   shift_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .load_val(load_val), .dir(dir),
      .amount(amount), .fill(fill), .reg_q(reg_q), .mode(mode), .data_in(data_in),
      .shift_in_left(shift_in_left), .shift_in_right(shift_in_right),
      .busy(busy), .done(done), .result(result)
   );

   shift_reg_lr u_sr (
      .clk(clk), .rst(rst), .mode(mode), .data_in(data_in),
      .shift_in_left(shift_in_left), .shift_in_right(shift_in_right),
      .data_out(reg_q)
   );

   typedef struct {
      logic [7:0] ld;
      logic       d;
      logic [1:0] f;
      logic [3:0] a;
      logic [7:0] exp_res;
      int         exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: the whole shift done at once with integer arithmetic.
   function automatic logic [7:0] model(input logic [7:0] v, input logic d,
                                        input logic [1:0] f, input int amt, output int n);
      int x, r, sx;
      x = int'(v);
      r = 0;
      n = (f == 2'b10) ? amt % 8 : (amt > 8 ? 8 : amt);
      if (!d) begin
         case (f)
            2'b00: r = x >> n;
            2'b01: r = (x >> n) | (255 << (8 - n));
            2'b10: r = (x >> n) | (x << (8 - n));
            default: begin
               sx = v[7] ? x - 256 : x;
               r  = sx >>> n;
            end
         endcase
      end else begin
         case (f)
            2'b01:   r = (x << n) | ((1 << n) - 1);
            2'b10:   r = (x << n) | (x >> (8 - n));
            default: r = x << n;
         endcase
      end
      return r[7:0];
   endfunction

   // Issue one request and follow it to its done pulse; mode is logged each cycle.
   task automatic run_op(input logic [7:0] ld, input logic d, input logic [1:0] f,
                         input logic [3:0] a, output logic [7:0] res, output int lat);
      load_val = ld; dir = d; fill = f; amount = a; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      load_val = 8'($urandom); dir = 1'($urandom); fill = 2'($urandom); amount = 4'($urandom);
      mode_log.delete();
      mode_log.push_back(mode);
      lat = -1;
      res = 8'hxx;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            res = result;
            break;
         end
         mode_log.push_back(mode);
      end
   endtask

   task automatic check_modes(input string name, input logic d, input int n);
      int bad = 0;
      logic [1:0] e;
      if (mode_log.size() != n + 2) bad++;
      for (int i = 0; i < mode_log.size(); i++) begin
         e = (i == 0) ? 2'b11 : ((i <= n) ? (d ? 2'b10 : 2'b01) : 2'b00);
         if (mode_log[i] !== e) bad++;
      end
      check(name, 32'(bad), 32'd0);
   endtask

   task automatic gap_check();
      @(posedge clk); #1;
      check("done_pulse_width", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      vec_t vecs[9];
      logic [7:0] res, exp_r;
      int lat, n, ndone;
      logic [7:0] first_res;

      vecs[0] = '{8'hB4, 1'b0, 2'b00, 4'd3,  8'h16, 5};
      vecs[1] = '{8'h81, 1'b1, 2'b10, 4'd1,  8'h03, 3};
      vecs[2] = '{8'h01, 1'b0, 2'b10, 4'd10, 8'h40, 4};
      vecs[3] = '{8'h90, 1'b0, 2'b11, 4'd2,  8'hE4, 4};
      vecs[4] = '{8'h90, 1'b1, 2'b11, 4'd2,  8'h40, 4};
      vecs[5] = '{8'h5A, 1'b0, 2'b00, 4'd0,  8'h5A, 2};
      vecs[6] = '{8'hFF, 1'b1, 2'b00, 4'd12, 8'h00, 10};
      vecs[7] = '{8'h00, 1'b0, 2'b01, 4'd15, 8'hFF, 10};
      vecs[8] = '{8'hA5, 1'b1, 2'b10, 4'd8,  8'hA5, 2};

      rst = 1'b0; start = 1'b0; load_val = '0; dir = 1'b0; amount = '0; fill = '0;
      #1;
      check("rst_mode", 32'(mode), 32'd0);
      check("rst_data_in", 32'(data_in), 32'd0);
      check("rst_fill_bits", 32'({shift_in_left, shift_in_right}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed table from the operation list.
      foreach (vecs[i]) begin
         run_op(vecs[i].ld, vecs[i].d, vecs[i].f, vecs[i].a, res, lat);
         check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         check_modes($sformatf("vec%0d_modes", i), vecs[i].d, vecs[i].exp_lat - 2);
         gap_check();
      end

      // Start pulsed during SHIFT must be dropped.
      load_val = 8'hB4; dir = 1'b0; fill = 2'b00; amount = 4'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; load_val = 8'hFF; dir = 1'b1; amount = 4'd1;
      @(posedge clk); #1; start = 1'b0;
      ndone = 0; first_res = 8'h00;
      for (int k = 0; k < 20; k++) begin
         if (done) begin
            if (ndone == 0) first_res = result;
            ndone++;
         end
         @(posedge clk); #1;
      end
      check("busy_start_ignored_count", 32'(ndone), 32'd1);
      check("busy_start_ignored_result", 32'(first_res), 32'h16);

      // Back-to-back: second request issued in the done cycle.
      run_op(8'h81, 1'b1, 2'b10, 4'd1, res, lat);
      check("b2b_first_result", 32'(res), 32'h03);
      run_op(8'hB4, 1'b0, 2'b00, 4'd3, res, lat);
      check("b2b_second_result", 32'(res), 32'h16);
      check("b2b_second_latency", 32'(lat), 32'd5);
      gap_check();

      // Randomized operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         logic [7:0] r_ld;
         logic       r_d;
         logic [1:0] r_f;
         logic [3:0] r_a;
         r_ld = 8'($urandom); r_d = 1'($urandom); r_f = 2'($urandom);
         r_a = 4'($urandom_range(0, 15));
         exp_r = model(r_ld, r_d, r_f, int'(r_a), n);
         run_op(r_ld, r_d, r_f, r_a, res, lat);
         check($sformatf("rand%0d_result", i), 32'(res), 32'(exp_r));
         check($sformatf("rand%0d_latency", i), 32'(lat), 32'(n + 2));
         check_modes($sformatf("rand%0d_modes", i), r_d, n);
         if (($urandom & 1) != 0) gap_check();
      end
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a shift run.
      load_val = 8'hC3; dir = 1'b1; fill = 2'b01; amount = 4'd8; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_mode", 32'(mode), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      run_op(8'h90, 1'b0, 2'b11, 4'd2, res, lat);
      check("post_rst_result", 32'(res), 32'hE4);
      check("post_rst_latency", 32'(lat), 32'd4);
      check_modes("post_rst_modes", 1'b0, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for the 8-bit bidirectional shift register (shift_reg_lr). It accepts a one-cycle start request with operand, direction, shift amount and fill policy. It then drives the register's mode/data_in/shift_in_left/shift_in_right pins through load, then N shift cycles, then hold, and returns the final register value with a done pulse. It sits between the datapath control unit and shift_reg_lr, so higher levels issue whole shift operations instead of per-cycle mode codes.

Parameters:
WIDTH, 8, register width; fixed to 8 for shift_reg_lr, kept for package consistency
CNT_W, 4, width of amount input and internal counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request; sampled only in IDLE
load_val  input  8  operand to load
dir  input  1  0 = shift right (toward LSB), 1 = shift left (toward MSB)
amount  input  4  requested shift count 0..15
fill  input  2  00 zero, 01 one, 10 rotate, 11 arithmetic
reg_q  input  8  data_out of shift_reg_lr
mode  output  2  to shift_reg_lr: 00 hold, 01 right, 10 left, 11 load
data_in  output  8  to shift_reg_lr parallel load
shift_in_left  output  1  MSB fill bit for right shifts
shift_in_right  output  1  LSB fill bit for left shifts
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse; result valid
result  output  8  final register value, held until the next done

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, latched config=0, done=0, result=0x00; mode=00, data_in=0, fill bits=0, busy=0.
- States: IDLE, LOAD, SHIFT, DONE. mode/data_in/shift_in_* decode combinationally from state and latched config.
- IDLE: mode=00. On an edge with start=1, latch load_val, dir, fill and the effective count n, then go to LOAD. Any done pulse clears on this edge.
- Effective count: for fill=10 (rotate), n = amount mod 8. Otherwise n = min(amount, 8).
- LOAD: mode=11, data_in=latched load_val. Go to SHIFT if n>0, else go to DONE.
- SHIFT: mode = dir ? 10 : 01. Counter counts n cycles; after the nth cycle, go to DONE.
- Fill, right shift (shift_in_left): zero->0, one->1, rotate->reg_q[0], arith->reg_q[7].
- Fill, left shift (shift_in_right): zero->0, one->1, rotate->reg_q[7], arith->0.
- The unused shift_in_* pin is driven 0.
- DONE: mode=00. On the next edge, result<=reg_q, done<=1, state->IDLE.
- Latency: start sampled at edge 0. Load at edge 1; shifts at edges 2..n+1; done high during the cycle after edge n+2. busy is high from edge 0 to edge n+2.
- start while busy, or in the same cycle done is high (state IDLE), is handled as follows. Busy: ignored, not queued. IDLE with done high: accepted normally.
- Input changes after the start edge have no effect; the operation uses the latched config.
- Reset mid-operation returns to IDLE immediately with mode=00. Shift register contents are governed by its own reset.

Decomposition:
- Shared package: state encoding (IDLE/LOAD/SHIFT/DONE), mode codes (MODE_HOLD=00, MODE_RIGHT=01, MODE_LEFT=10, MODE_LOAD=11), fill codes (FILL_ZERO/ONE/ROT/ARITH), WIDTH.
- Optional sub-module shift_fill_sel: combinational fill-bit selection from dir, fill and reg_q.
- The bench instantiates shift_seq_ctrl and shift_reg_lr together, with reg_q tied to data_out.

Test Plan:
- load 0xB4, dir=0, fill=00, amount=3 -> mode sequence 11,01,01,01,00; done after edge 5; result=0x16.
- load 0x81, dir=1, fill=10, amount=1 -> result=0x03; load 0x01, dir=0, fill=10, amount=10 -> n=2, result=0x40, done after edge 4.
- load 0x90, dir=0, fill=11, amount=2 -> result=0xE4; same with dir=1 -> result=0x40.
- load 0x5A, amount=0 -> mode 11 then 00, done after edge 2, result=0x5A. load 0xFF, dir=1, fill=00, amount=12 -> n=8, result=0x00. fill=01, dir=0, load 0x00, amount=15 -> result=0xFF.
- start pulsed again during SHIFT -> ignored: exactly one done, result matches the first request. Back-to-back start in the done cycle -> second operation runs.
- rst driven low during SHIFT (async, mid-cycle) -> busy=0 and mode=00 without waiting for a clock edge, done=0, result=0x00. After rst returns high, a new start completes normally.
